// File: rtl/dnn2ami_wr_splitter_if.sv
// Bus bundle between dnn2ami_wr_splitter and its environment: macro write
// queue head, per-PU output buffers and the AMI write beat channel.
// master = the splitter side, slave = queue/buffer/AMI side.
interface dnn2ami_wr_splitter_if #(
  parameter int unsigned NUM_PU = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned SIZE_W = 32,
  parameter int unsigned DATA_W = 512
);
  localparam int unsigned PU_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  // macro write queue head
  logic                       mq_empty;
  logic [ADDR_W-1:0]          mq_addr;
  logic [SIZE_W-1:0]          mq_size;
  logic [PU_W-1:0]            mq_pu;
  logic                       mq_deq;

  // per-PU output buffers
  logic [NUM_PU-1:0]          outbuf_empty;
  logic [NUM_PU*DATA_W-1:0]   outbuf_data;
  logic [NUM_PU-1:0]          outbuf_pop;

  // AMI write beat channel
  logic                       ami_wr_valid;
  logic [ADDR_W-1:0]          ami_wr_addr;
  logic [DATA_W-1:0]          ami_wr_data;
  logic                       ami_wr_ready;

  modport master (
    input  mq_empty, mq_addr, mq_size, mq_pu,
    output mq_deq,
    input  outbuf_empty, outbuf_data,
    output outbuf_pop,
    output ami_wr_valid, ami_wr_addr, ami_wr_data,
    input  ami_wr_ready
  );

  modport slave (
    output mq_empty, mq_addr, mq_size, mq_pu,
    input  mq_deq,
    output outbuf_empty, outbuf_data,
    input  outbuf_pop,
    input  ami_wr_valid, ami_wr_addr, ami_wr_data,
    output ami_wr_ready
  );
endinterface

// File: rtl/dnn2ami_wr_splitter.sv
// dnn2ami_wr_splitter: pops one macro write request, splits it into
// BEAT_BYTES-sized AMI write beats, pulls one data word per beat from the
// selected PU output buffer and issues each beat on a valid/ready channel.
// Optional build macro: DNN2AMI_WR_TRACE_EN enables request/beat/error trace
// messages; ports and timing are identical with or without it.
module dnn2ami_wr_splitter #(
  parameter int unsigned NUM_PU     = 2,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned SIZE_W     = 32,
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned BEAT_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  dnn2ami_wr_splitter_if.master bus,
  output logic                  busy,
  output logic                  req_err
);

  localparam int unsigned PU_W  = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
  localparam int unsigned SHIFT = $clog2(BEAT_BYTES);
  // one extra bit so a full-size request rounded up still fits
  localparam int unsigned CNT_W = SIZE_W - SHIFT + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic [PU_W-1:0]     pu_q, pu_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;

  logic                mq_deq_c;
  logic [NUM_PU-1:0]   pop_c;
  logic                pu_bad_c;
  logic                req_bad_c;
  logic [CNT_W-1:0]    req_beats_c;
  logic [DATA_W-1:0]   pu_data [NUM_PU];

  // Unpack the flat per-PU head-word bus into one word per PU.
  always_comb begin
    for (int i = 0; i < NUM_PU; i++) begin
      pu_data[i] = bus.outbuf_data[i*DATA_W +: DATA_W];
    end
  end

  // A PU index can only be out of range when NUM_PU is not a power of two.
  if ((1 << PU_W) == NUM_PU) begin : g_pu_full
    assign pu_bad_c = 1'b0;
  end else begin : g_pu_part
    assign pu_bad_c = (32'(bus.mq_pu) >= NUM_PU);
  end

  // Beat count is the size rounded up to whole beats; a partial tail still costs a full beat.
  assign req_beats_c = CNT_W'(bus.mq_size >> SHIFT) + CNT_W'(|bus.mq_size[SHIFT-1:0]);
  assign req_bad_c   = (bus.mq_size == '0) || pu_bad_c;

  // Next-state and strobe logic; strobes are forced low while reset is held.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    pu_d     = pu_q;
    valid_d  = valid_q;
    data_d   = data_q;
    err_d    = err_q;
    mq_deq_c = 1'b0;
    pop_c    = '0;

    unique case (state_q)
      IDLE: begin
        if (!bus.mq_empty) begin
          mq_deq_c = 1'b1;
          if (req_bad_c) begin
            err_d = 1'b1;
          end else begin
            addr_d  = bus.mq_addr;
            pu_d    = bus.mq_pu;
            beats_d = req_beats_c;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (!bus.outbuf_empty[pu_q]) begin
          pop_c[pu_q] = 1'b1;
          data_d      = pu_data[pu_q];
          valid_d     = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (bus.ami_wr_ready) begin
          valid_d = 1'b0;
          addr_d  = addr_q + ADDR_W'(BEAT_BYTES);
          beats_d = beats_q - CNT_W'(1);
          state_d = (beats_q == CNT_W'(1)) ? IDLE : LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (rst) begin
      mq_deq_c = 1'b0;
      pop_c    = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      pu_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      pu_q    <= pu_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.mq_deq       = mq_deq_c;
  assign bus.outbuf_pop   = pop_c;
  assign bus.ami_wr_valid = valid_q;
  assign bus.ami_wr_addr  = addr_q;
  assign bus.ami_wr_data  = data_q;
  assign busy             = (state_q != IDLE);
  assign req_err          = err_q;

`ifdef DNN2AMI_WR_TRACE_EN
  // Trace accepted requests, handshaken beats and malformed requests.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (mq_deq_c && !req_bad_c) begin
        $display("DNN2AMI: WR split addr %h size %d pu %d", bus.mq_addr, bus.mq_size, bus.mq_pu);
      end
      if (mq_deq_c && req_bad_c) begin
        $display("DNN2AMI: WR req_err addr %h size %d pu %d", bus.mq_addr, bus.mq_size, bus.mq_pu);
      end
      if (valid_q && bus.ami_wr_ready) begin
        $display("DNN2AMI: WR beat addr %h", addr_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dnn2ami_wr_splitter.sv
// Scoreboard bench for dnn2ami_wr_splitter: requests are issued into a
// queue model, expected beats are computed at issue time, and independent
// processes check the queue/buffer side and the AMI side.
module tb_dnn2ami_wr_splitter;
  localparam int unsigned NUM_PU = 2;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned SIZE_W = 32;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned BB     = 64;
  localparam int unsigned PU_W   = 1;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] size;
    int          pu;
  } req_t;

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] data;
  } beat_t;

  logic clk;
  logic rst;
  logic busy;
  logic req_err;

  dnn2ami_wr_splitter_if #(.NUM_PU(NUM_PU), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .DATA_W(DATA_W)) bus ();

  dnn2ami_wr_splitter #(
    .NUM_PU(NUM_PU), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .DATA_W(DATA_W), .BEAT_BYTES(BB)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .req_err (req_err)
  );

  // models and knobs
  req_t          mq_model[$];
  beat_t         exp_q[$];
  logic [511:0]  buf_q[NUM_PU][$];
  bit            exp_err;
  bit            hold_mq;
  int            gap_pct;
  int            rdy_pct;
  int            ob_stall_pct;
  bit            rdy_ovr_en;
  bit            rdy_ovr_val;
  bit [NUM_PU-1:0] ob_force_empty;

  // statistics
  int checks;
  int errors;
  int cyc;
  int deq_cnt;
  int deq_cyc;
  int hs_cnt;
  int pop_cnt[NUM_PU];
  bit lat_arm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Issue one request: the reference model expands it into expected beats.
  task automatic issue(input logic [63:0] a, input logic [31:0] s, input int p);
    req_t  r;
    beat_t b;
    int    nb;
    r.addr = a;
    r.size = s;
    r.pu   = p;
    mq_model.push_back(r);
    if (s == 0 || p >= int'(NUM_PU)) begin
      exp_err = 1'b1;
    end else begin
      nb = int'((longint'(s) + 63) / 64);
      for (int k = 0; k < nb; k++) begin
        b.addr = a + 64'(k * BB);
        b.data = rand_word();
        buf_q[p].push_back(b.data);
        exp_q.push_back(b);
      end
    end
  endtask

  // Environment driver: present queue head, buffer heads and ready after each edge.
  task automatic drive_inputs();
    bus.mq_empty = hold_mq || (mq_model.size() == 0) || ($urandom_range(0, 99) < gap_pct);
    if (mq_model.size() != 0) begin
      bus.mq_addr = mq_model[0].addr;
      bus.mq_size = mq_model[0].size;
      bus.mq_pu   = PU_W'(mq_model[0].pu);
    end
    for (int i = 0; i < NUM_PU; i++) begin
      bus.outbuf_empty[i] = (buf_q[i].size() == 0) || ob_force_empty[i] ||
                            ($urandom_range(0, 99) < ob_stall_pct);
      bus.outbuf_data[i*DATA_W +: DATA_W] = (buf_q[i].size() != 0) ? buf_q[i][0] : '0;
    end
    bus.ami_wr_ready = rdy_ovr_en ? rdy_ovr_val : ($urandom_range(0, 99) < rdy_pct);
  endtask

  initial begin
    bus.mq_empty     = 1'b1;
    bus.mq_addr      = '0;
    bus.mq_size      = '0;
    bus.mq_pu        = '0;
    bus.outbuf_empty = '1;
    bus.outbuf_data  = '0;
    bus.ami_wr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      drive_inputs();
    end
  end

  // Queue/buffer-side checker: dequeues and pops must be legal and update the models.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mq_deq) begin
        chk(!bus.mq_empty && mq_model.size() != 0, "deq_legal", 64'(bus.mq_empty), 64'd0);
        if (mq_model.size() != 0) void'(mq_model.pop_front());
        deq_cnt++;
        deq_cyc = cyc;
      end
      if (|bus.outbuf_pop) begin
        chk($onehot(bus.outbuf_pop), "pop_onehot", 64'(bus.outbuf_pop), 64'd1);
        chk(!bus.ami_wr_valid, "pop_while_valid", 64'(bus.ami_wr_valid), 64'd0);
        for (int i = 0; i < NUM_PU; i++) begin
          if (bus.outbuf_pop[i]) begin
            chk(!bus.outbuf_empty[i] && buf_q[i].size() != 0, "pop_nonempty",
                64'(bus.outbuf_empty[i]), 64'd0);
            if (buf_q[i].size() != 0) void'(buf_q[i].pop_front());
            pop_cnt[i]++;
          end
        end
      end
    end
  end

  // AMI-side monitor: compare each handshaken beat against the scoreboard.
  bit           prev_valid;
  bit           prev_hs;
  logic [63:0]  prev_addr;
  logic [511:0] prev_data;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (bus.ami_wr_valid) begin
        if (prev_valid && !prev_hs) begin
          chk(bus.ami_wr_addr == prev_addr, "hold_addr", bus.ami_wr_addr, prev_addr);
          chk(bus.ami_wr_data == prev_data, "hold_data", bus.ami_wr_data[63:0], prev_data[63:0]);
        end
        if (!prev_valid && lat_arm) begin
          chk(cyc - deq_cyc == 2, "first_beat_latency", 64'(cyc - deq_cyc), 64'd2);
          lat_arm = 1'b0;
        end
        if (bus.ami_wr_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_beat", bus.ami_wr_addr, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk(bus.ami_wr_addr == e.addr, "beat_addr", bus.ami_wr_addr, e.addr);
            chk(bus.ami_wr_data == e.data, "beat_data", bus.ami_wr_data[63:0], e.data[63:0]);
          end
        end
      end
      prev_valid = bus.ami_wr_valid;
      prev_hs    = bus.ami_wr_valid && bus.ami_wr_ready;
      prev_addr  = bus.ami_wr_addr;
      prev_data  = bus.ami_wr_data;
    end
  end

  // Wait for all issued work to finish, then check idle state and sticky error.
  task automatic drain(input int bound);
    int n;
    n = 0;
    hold_mq = 1'b0;
    while ((mq_model.size() != 0 || exp_q.size() != 0 || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk(n < bound, "drain_timeout", 64'(n), 64'(bound));
    chk(exp_q.size() == 0, "beats_outstanding", 64'(exp_q.size()), 64'd0);
    chk(!busy, "busy_after_drain", 64'(busy), 64'd0);
    chk(req_err == exp_err, "req_err", 64'(req_err), 64'(exp_err));
    for (int i = 0; i < NUM_PU; i++) begin
      chk(buf_q[i].size() == 0, "buffer_leftover", 64'(buf_q[i].size()), 64'd0);
    end
    hold_mq = 1'b1;
  endtask

  task automatic wait_hs(input int target, input int bound);
    int n;
    n = 0;
    while (hs_cnt < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(n < bound, "wait_handshake_timeout", 64'(n), 64'(bound));
  endtask

  task automatic wait_valid(input int bound);
    int n;
    n = 0;
    while (!bus.ami_wr_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(n < bound, "wait_valid_timeout", 64'(n), 64'(bound));
  endtask

  task automatic check_quiet(input string tag);
    chk(!bus.ami_wr_valid, {tag, "_valid"}, 64'(bus.ami_wr_valid), 64'd0);
    chk(bus.ami_wr_addr == '0, {tag, "_addr"}, bus.ami_wr_addr, 64'd0);
    chk(bus.ami_wr_data == '0, {tag, "_data"}, bus.ami_wr_data[63:0], 64'd0);
    chk(!busy, {tag, "_busy"}, 64'(busy), 64'd0);
    chk(!req_err, {tag, "_req_err"}, 64'(req_err), 64'd0);
    chk(!bus.mq_deq, {tag, "_mq_deq"}, 64'(bus.mq_deq), 64'd0);
    chk(bus.outbuf_pop == '0, {tag, "_pop"}, 64'(bus.outbuf_pop), 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, h0, p0, p1;
    logic [63:0] a;
    rst = 1'b1;
    hold_mq = 1'b1;
    exp_err = 1'b0;
    gap_pct = 0;
    rdy_pct = 100;
    ob_stall_pct = 0;
    rdy_ovr_en = 1'b0;
    rdy_ovr_val = 1'b1;
    ob_force_empty = '0;
    lat_arm = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("post_reset");

    // 1) 256 bytes from PU0, full-rate ready, first-beat latency
    d0 = deq_cnt; h0 = hs_cnt; p0 = pop_cnt[0];
    issue(64'h1000, 32'd256, 0);
    lat_arm = 1'b1;
    drain(200);
    chk(deq_cnt - d0 == 1, "t1_deq_count", 64'(deq_cnt - d0), 64'd1);
    chk(hs_cnt - h0 == 4, "t1_beats", 64'(hs_cnt - h0), 64'd4);
    chk(pop_cnt[0] - p0 == 4, "t1_pops_pu0", 64'(pop_cnt[0] - p0), 64'd4);
    chk(!lat_arm, "t1_latency_seen", 64'(lat_arm), 64'd0);

    // 2) partial tail: 100 bytes from PU1
    h0 = hs_cnt; p1 = pop_cnt[1];
    issue(64'h2000, 32'd100, 1);
    drain(200);
    chk(hs_cnt - h0 == 2, "t2_beats", 64'(hs_cnt - h0), 64'd2);
    chk(pop_cnt[1] - p1 == 2, "t2_pops_pu1", 64'(pop_cnt[1] - p1), 64'd2);

    // 3) zero-size request is dropped with req_err, the next one proceeds
    d0 = deq_cnt; h0 = hs_cnt; p0 = pop_cnt[0]; p1 = pop_cnt[1];
    issue(64'h3000, 32'd0, 0);
    issue(64'h3100, 32'd64, 1);
    drain(200);
    chk(deq_cnt - d0 == 2, "t3_deq_count", 64'(deq_cnt - d0), 64'd2);
    chk(hs_cnt - h0 == 1, "t3_beats", 64'(hs_cnt - h0), 64'd1);
    chk(pop_cnt[0] == p0, "t3_no_pop_pu0", 64'(pop_cnt[0]), 64'(p0));
    chk(pop_cnt[1] - p1 == 1, "t3_pop_pu1", 64'(pop_cnt[1] - p1), 64'd1);

    // 4) backpressure on beat 2 of 3
    rdy_ovr_en = 1'b1; rdy_ovr_val = 1'b1;
    h0 = hs_cnt;
    issue(64'h4000, 32'd192, 0);
    hold_mq = 1'b0;
    wait_hs(h0 + 1, 100);
    rdy_ovr_val = 1'b0;
    wait_valid(50);
    p0 = pop_cnt[0];
    repeat (10) begin
      @(negedge clk);
      chk(bus.ami_wr_valid, "t4_stall_valid", 64'(bus.ami_wr_valid), 64'd1);
    end
    chk(pop_cnt[0] == p0, "t4_no_pop_stalled", 64'(pop_cnt[0]), 64'(p0));
    chk(hs_cnt - h0 == 1, "t4_stalled_count", 64'(hs_cnt - h0), 64'd1);
    rdy_ovr_val = 1'b1;
    drain(200);
    chk(hs_cnt - h0 == 3, "t4_beats", 64'(hs_cnt - h0), 64'd3);
    rdy_ovr_en = 1'b0;

    // 5) empty buffer in LOAD holds the FSM without pops or valid
    ob_force_empty[0] = 1'b1;
    p0 = pop_cnt[0];
    issue(64'h5000, 32'd64, 0);
    hold_mq = 1'b0;
    repeat (3) @(negedge clk);
    chk(busy, "t5_busy_loading", 64'(busy), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk(!bus.ami_wr_valid && bus.outbuf_pop == '0, "t5_starved_quiet",
          {62'd0, bus.ami_wr_valid, |bus.outbuf_pop}, 64'd0);
    end
    ob_force_empty[0] = 1'b0;
    @(negedge clk);
    chk(bus.outbuf_pop[0], "t5_pop_on_data", 64'(bus.outbuf_pop), 64'd1);
    drain(200);
    chk(pop_cnt[0] - p0 == 1, "t5_pop_count", 64'(pop_cnt[0] - p0), 64'd1);

    // 6a) address wraps past the top of the 64-bit space
    issue(64'hFFFF_FFFF_FFFF_FFC0, 32'd128, 1);
    drain(200);

    // 6b) reset while a beat is held by backpressure
    rdy_ovr_en = 1'b1; rdy_ovr_val = 1'b0;
    issue(64'h6000, 32'd192, 0);
    hold_mq = 1'b0;
    wait_valid(50);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("mid_reset");
    mq_model.delete();
    exp_q.delete();
    for (int i = 0; i < NUM_PU; i++) buf_q[i].delete();
    exp_err = 1'b0;
    hold_mq = 1'b1;
    rdy_ovr_en = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("held_reset");
    rst = 1'b0;
    @(negedge clk);
    issue(64'h7000, 32'd130, 1);
    drain(200);

    // 7) randomized requests with random gaps, stalls and backpressure
    gap_pct = 20; rdy_pct = 70; ob_stall_pct = 20;
    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom};
      issue(a, ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 320)),
            int'($urandom_range(0, NUM_PU - 1)));
    end
    drain(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
